// File: rtl/operand_entry.sv
// rtl/operand_entry.sv - two-press operand capture with synchronised, debounced key and valid/ready output
// A first accepted press latches A; a second latches B and op, then the operand set is presented until accepted.

module operand_entry #(
   parameter int N               = 4,
   parameter int DEBOUNCE_CYCLES = 4
) (
   input  logic         CLOCK_50,
   input  logic         resetn,
   input  logic [N-1:0] sw_data,
   input  logic         sw_op,
   input  logic         key_n,
   input  logic         out_ready,
   output logic [N-1:0] a_out,
   output logic [N-1:0] b_out,
   output logic         op_out,
   output logic         out_valid,
   output logic [1:0]   state_out
);

   localparam int            CW       = $clog2(DEBOUNCE_CYCLES);
   localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

   typedef enum logic [1:0] {
      GET_A   = 2'b00,
      GET_B   = 2'b01,
      PRESENT = 2'b10,
      BAD     = 2'b11
   } state_t;

   logic          s1_q, s2_q;
   logic          db_level_q, db_level_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          press;

   state_t        state_q, state_d;
   logic [N-1:0]  a_q, a_d, b_q, b_d;
   logic          op_q, op_d, valid_q, valid_d;

   always_ff @(posedge CLOCK_50) begin
      if (!resetn) begin
         s1_q       <= 1'b1;
         s2_q       <= 1'b1;
         db_level_q <= 1'b1;
         cnt_q      <= '0;
      end else begin
         s1_q       <= key_n;
         s2_q       <= s1_q;
         db_level_q <= db_level_d;
         cnt_q      <= cnt_d;
      end
   end

   // Any sample matching the accepted level restarts the stability count.
   always_comb begin
      cnt_d      = cnt_q;
      db_level_d = db_level_q;
      press      = 1'b0;
      if (s2_q == db_level_q) begin
         cnt_d = '0;
      end else if (cnt_q == CNT_LAST) begin
         db_level_d = s2_q;
         cnt_d      = '0;
         press      = ~s2_q;
      end else begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge CLOCK_50) begin
      if (!resetn) begin
         state_q <= GET_A;
         a_q     <= '0;
         b_q     <= '0;
         op_q    <= 1'b0;
         valid_q <= 1'b0;
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         b_q     <= b_d;
         op_q    <= op_d;
         valid_q <= valid_d;
      end
   end

   // Presses seen while presenting are dropped, including one coinciding with the transfer.
   always_comb begin
      state_d = state_q;
      a_d     = a_q;
      b_d     = b_q;
      op_d    = op_q;
      valid_d = valid_q;
      case (state_q)
         GET_A: begin
            if (press) begin
               a_d     = sw_data;
               state_d = GET_B;
            end
         end
         GET_B: begin
            if (press) begin
               b_d     = sw_data;
               op_d    = sw_op;
               valid_d = 1'b1;
               state_d = PRESENT;
            end
         end
         PRESENT: begin
            if (out_ready) begin
               valid_d = 1'b0;
               state_d = GET_A;
            end
         end
         default: begin
            valid_d = 1'b0;
            state_d = GET_A;
         end
      endcase
   end

   assign a_out     = a_q;
   assign b_out     = b_q;
   assign op_out    = op_q;
   assign out_valid = valid_q;
   assign state_out = state_q;

endmodule

// File: tb/tb_operand_entry.sv
// tb/tb_operand_entry.sv - vector table, directed corner sequences and randomized model comparison for operand_entry

module tb_operand_entry;

   localparam int N = 4;
   localparam int D = 4;

   logic         CLOCK_50 = 1'b0;
   logic         resetn   = 1'b0;
   logic [N-1:0] sw_data  = '0;
   logic         sw_op    = 1'b0;
   logic         key_n    = 1'b1;
   logic         out_ready = 1'b0;
   logic [N-1:0] a_out, b_out;
   logic         op_out, out_valid;
   logic [1:0]   state_out;

   int checks = 0;
   int errors = 0;

   always #5 CLOCK_50 = ~CLOCK_50;

   operand_entry #(.N(N), .DEBOUNCE_CYCLES(D)) dut (
      .CLOCK_50  (CLOCK_50),
      .resetn    (resetn),
      .sw_data   (sw_data),
      .sw_op     (sw_op),
      .key_n     (key_n),
      .out_ready (out_ready),
      .a_out     (a_out),
      .b_out     (b_out),
      .op_out    (op_out),
      .out_valid (out_valid),
      .state_out (state_out)
   );

   // Reference: two-sample delay line, then a level flips once the last D delayed samples all disagree with it.
   bit   m_sync [0:1];
   bit   m_win [$];
   bit   m_db;
   int   m_state, m_a, m_b, m_op, m_valid;

   task automatic model_reset();
      m_sync[0] = 1'b1;
      m_sync[1] = 1'b1;
      m_win.delete();
      m_db    = 1'b1;
      m_state = 0;
      m_a     = 0;
      m_b     = 0;
      m_op    = 0;
      m_valid = 0;
   endtask

   task automatic model_step();
      bit pr;
      bit all_diff;
      if (!resetn) begin
         model_reset();
      end else begin
         pr = 1'b0;
         m_win.push_back(m_sync[1]);
         if (m_win.size() > D) void'(m_win.pop_front());
         if (m_win.size() == D) begin
            all_diff = 1'b1;
            foreach (m_win[i]) if (m_win[i] == m_db) all_diff = 1'b0;
            if (all_diff) begin
               m_db = ~m_db;
               pr   = (m_db == 1'b0);
            end
         end
         m_sync[1] = m_sync[0];
         m_sync[0] = key_n;
         case (m_state)
            0: if (pr) begin m_a = int'(sw_data); m_state = 1; end
            1: if (pr) begin m_b = int'(sw_data); m_op = int'(sw_op); m_valid = 1; m_state = 2; end
            default: if (out_ready) begin m_valid = 0; m_state = 0; end
         endcase
      end
   endtask

   task automatic check(string name, int got, int exp);
      checks++;
      if (got != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge CLOCK_50);
      model_step();
      #1;
      check("model_a",     int'(a_out),     m_a);
      check("model_b",     int'(b_out),     m_b);
      check("model_op",    int'(op_out),    m_op);
      check("model_valid", int'(out_valid), m_valid);
      check("model_state", int'(state_out), m_state);
   endtask

   // Key low for 10 cycles then high for 10; the press must land exactly on the (D+2)th low cycle.
   task automatic press_expect(string name, logic [N-1:0] val, logic opv,
                               int st_before, int st_after, int st_after2);
      sw_data = val;
      sw_op   = opv;
      key_n   = 1'b0;
      repeat (D + 1) tick();
      check({name, "_pre"}, int'(state_out), st_before);
      tick();
      check({name, "_post"}, int'(state_out), st_after);
      tick();
      check({name, "_next"}, int'(state_out), st_after2);
      repeat (10 - (D + 3)) tick();
      key_n = 1'b1;
      repeat (10) tick();
   endtask

   typedef struct {
      logic [N-1:0] a;
      logic [N-1:0] b;
      logic         op;
      int           wait_cycles;
      logic [N-1:0] ea;
      logic [N-1:0] eb;
      logic         eop;
   } vec_t;

   vec_t vecs [5];

   initial begin
      vecs[0] = '{4'h5, 4'h3, 1'b0, 0, 4'h5, 4'h3, 1'b0};
      vecs[1] = '{4'h5, 4'h3, 1'b0, 6, 4'h5, 4'h3, 1'b0};
      vecs[2] = '{4'hA, 4'hC, 1'b1, 2, 4'hA, 4'hC, 1'b1};
      vecs[3] = '{4'hF, 4'h0, 1'b1, 0, 4'hF, 4'h0, 1'b1};
      vecs[4] = '{4'h0, 4'hF, 1'b0, 3, 4'h0, 4'hF, 1'b0};

      model_reset();
      resetn = 1'b0;
      tick();
      tick();
      check("rst_a",     int'(a_out),     0);
      check("rst_b",     int'(b_out),     0);
      check("rst_op",    int'(op_out),    0);
      check("rst_valid", int'(out_valid), 0);
      check("rst_state", int'(state_out), 0);
      resetn = 1'b1;
      tick();

      foreach (vecs[i]) begin
         out_ready = (vecs[i].wait_cycles == 0);
         press_expect("vecA", vecs[i].a, ~vecs[i].op, 0, 1, 1);
         check("vecA_a", int'(a_out), int'(vecs[i].ea));
         if (vecs[i].wait_cycles == 0) begin
            press_expect("vecB", vecs[i].b, vecs[i].op, 1, 2, 0);
            check("vec_valid_dropped", int'(out_valid), 0);
         end else begin
            press_expect("vecB", vecs[i].b, vecs[i].op, 1, 2, 2);
            for (int c = 0; c < vecs[i].wait_cycles; c++) begin
               tick();
               check("vec_hold_valid", int'(out_valid), 1);
               check("vec_hold_b", int'(b_out), int'(vecs[i].eb));
            end
            out_ready = 1'b1;
            tick();
            check("vec_xfer_valid", int'(out_valid), 0);
            check("vec_xfer_state", int'(state_out), 0);
         end
         check("vec_a",  int'(a_out),  int'(vecs[i].ea));
         check("vec_b",  int'(b_out),  int'(vecs[i].eb));
         check("vec_op", int'(op_out), int'(vecs[i].eop));
         out_ready = 1'b0;
      end

      // Three-cycle glitch is rejected; four cycles is just enough.
      sw_data = 4'h9;
      key_n   = 1'b0;
      repeat (3) tick();
      key_n = 1'b1;
      repeat (10) tick();
      check("glitch3_state", int'(state_out), 0);
      check("glitch3_a",     int'(a_out),     0);
      key_n = 1'b0;
      repeat (4) tick();
      key_n = 1'b1;
      tick();
      check("glitch4_pre", int'(state_out), 0);
      tick();
      check("glitch4_state", int'(state_out), 1);
      check("glitch4_a",     int'(a_out),     9);
      repeat (8) tick();

      // Bouncy press: counting starts again from the final low sample.
      sw_data = 4'h2;
      sw_op   = 1'b1;
      for (int i = 0; i < 6; i++) begin
         key_n = 1'(i % 2);
         tick();
      end
      key_n = 1'b0;
      repeat (D + 1) tick();
      check("bounce_pre", int'(state_out), 1);
      tick();
      check("bounce_state", int'(state_out), 2);
      check("bounce_b",     int'(b_out),     2);
      check("bounce_op",    int'(op_out),    1);
      repeat (4) tick();
      key_n = 1'b1;
      repeat (10) tick();

      // Press while presenting is discarded.
      sw_data = 4'hF;
      key_n   = 1'b0;
      repeat (10) tick();
      key_n = 1'b1;
      repeat (10) tick();
      check("present_a",     int'(a_out),     9);
      check("present_b",     int'(b_out),     2);
      check("present_state", int'(state_out), 2);
      out_ready = 1'b1;
      tick();
      check("present_xfer", int'(state_out), 0);
      out_ready = 1'b0;
      key_n = 1'b0;
      repeat (D + 2) tick();
      check("after_xfer_a",     int'(a_out),     15);
      check("after_xfer_state", int'(state_out), 1);
      repeat (4) tick();
      for (int i = 0; i < 5; i++) begin
         key_n = 1'((i + 1) % 2);
         tick();
      end
      key_n = 1'b1;
      repeat (10) tick();
      check("release_bounce_state", int'(state_out), 1);

      // Reset from GET_B, then a full entry.
      resetn = 1'b0;
      tick();
      resetn = 1'b1;
      press_expect("rA9", 4'h9, 1'b0, 0, 1, 1);
      check("rA9_a", int'(a_out), 9);
      resetn = 1'b0;
      tick();
      resetn = 1'b1;
      check("midrst_a",     int'(a_out),     0);
      check("midrst_b",     int'(b_out),     0);
      check("midrst_valid", int'(out_valid), 0);
      check("midrst_state", int'(state_out), 0);
      press_expect("rAF", 4'hF, 1'b0, 0, 1, 1);
      press_expect("rB1", 4'h1, 1'b1, 1, 2, 2);
      check("rst_entry_a",     int'(a_out),     15);
      check("rst_entry_b",     int'(b_out),     1);
      check("rst_entry_op",    int'(op_out),    1);
      check("rst_entry_valid", int'(out_valid), 1);

      // Key held low through reset release.
      key_n  = 1'b0;
      resetn = 1'b0;
      tick();
      tick();
      resetn = 1'b1;
      repeat (D + 1) tick();
      check("heldrst_pre", int'(state_out), 0);
      tick();
      check("heldrst_state", int'(state_out), 1);
      key_n = 1'b1;
      repeat (10) tick();

      for (int seg = 0; seg < 400; seg++) begin
         key_n     = 1'($urandom_range(0, 1));
         sw_data   = 4'($urandom);
         sw_op     = 1'($urandom);
         out_ready = 1'($urandom_range(0, 1));
         resetn    = ($urandom_range(0, 99) != 0);
         repeat ($urandom_range(1, 8)) tick();
         resetn = 1'b1;
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
